// File: rtl/fifo_push_arb.sv
`default_nettype none
// fifo_push_arb: round-robin push arbiter with burst lock and lock timeout for one FIFO push port.
// Optional per-requester beat counters: define FIFO_PUSH_ARB_STATS_EN. Rev 1.0
module fifo_push_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int LOCK_TO = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ-1:0]         req_lock_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       push_o,
  output logic [DATA_W-1:0]          data_o,
  input  logic                       full_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       locked_o,
  input  logic                       stat_clr_i,
  output logic [NUM_REQ*16-1:0]      stat_cnt_o
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] owner;
  logic [7:0]    to_cnt;

  logic [GW-1:0] scan_idx;
  logic          scan_hit;
  logic [GW-1:0] grant;
  logic          sel_valid;
  logic          sel_lock;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] p);
    return (p == GW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Circular search for the first valid requester starting at rr_ptr.
  always_comb begin
    int idx;
    idx      = 0;
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!scan_hit && req_valid_i[idx]) begin
        scan_hit = 1'b1;
        scan_idx = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    grant     = '0;
    sel_valid = 1'b0;
    if (state == LOCK) begin
      grant     = owner;
      sel_valid = req_valid_i[owner];
    end else if (scan_hit) begin
      grant     = scan_idx;
      sel_valid = 1'b1;
    end
    sel_lock = req_lock_i[grant];
  end

  // Reset gates the push path combinationally so nothing transfers while rst_i is high.
  assign push_o   = sel_valid & ~full_i & ~rst_i;
  assign grant_o  = grant;
  assign locked_o = (state == LOCK);
  assign data_o   = req_data_i[int'(grant)*DATA_W +: DATA_W];

  always_comb begin
    req_ready_o        = '0;
    req_ready_o[grant] = push_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      to_cnt <= '0;
    end else if (!full_i) begin
      if (state == IDLE) begin
        if (push_o) begin
          if (sel_lock) begin
            state  <= LOCK;
            owner  <= grant;
            to_cnt <= '0;
          end else begin
            rr_ptr <= next_idx(grant);
          end
        end
      end else begin
        if (push_o) begin
          if (sel_lock) begin
            to_cnt <= '0;
          end else begin
            state  <= IDLE;
            rr_ptr <= next_idx(owner);
            to_cnt <= '0;
          end
        end else if (to_cnt == 8'(LOCK_TO - 1)) begin
          // Owner went silent long enough: abandon the burst.
          state  <= IDLE;
          rr_ptr <= next_idx(owner);
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 8'd1;
        end
      end
    end
  end

`ifdef FIFO_PUSH_ARB_STATS_EN
  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
      logic [15:0] cnt;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt <= '0;
        end else if (stat_clr_i) begin
          cnt <= '0;
        end else if (req_ready_o[k] && (cnt != 16'hFFFF)) begin
          cnt <= cnt + 16'd1;
        end
      end
      assign stat_cnt_o[k*16 +: 16] = cnt;
    end
  endgenerate
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_cnt_o      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arb.sv
`default_nettype none
// tb_fifo_push_arb: directed self-checking bench for fifo_push_arb (4 requesters, LOCK_TO=16).
module tb_fifo_push_arb;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int LOCK_TO = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      push;
  logic [DATA_W-1:0]         data;
  logic                      full;
  logic [1:0]                grant;
  logic                      locked;
  logic                      stat_clr;
  logic [NUM_REQ*16-1:0]     stat_cnt;

  int checks = 0;
  int errors = 0;

`ifdef FIFO_PUSH_ARB_STATS_EN
  localparam logic [15:0] EXP_STAT5 = 16'd5;
`else
  localparam logic [15:0] EXP_STAT5 = 16'd0;
`endif

  fifo_push_arb #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .LOCK_TO(LOCK_TO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_lock_i (req_lock),
    .req_data_i (req_data),
    .req_ready_o(req_ready),
    .push_o     (push),
    .data_o     (data),
    .full_i     (full),
    .grant_o    (grant),
    .locked_o   (locked),
    .stat_clr_i (stat_clr),
    .stat_cnt_o (stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // An accepted beat from requester g: strobe, index, one-hot ready, payload and lock flag.
  task automatic expect_beat(input string tag, input int g, input logic lk);
    chk({tag, ".push"},   64'(push), 64'd1);
    chk({tag, ".grant"},  64'(grant), 64'(g));
    chk({tag, ".ready"},  64'(req_ready), 64'(1 << g));
    chk({tag, ".data"},   64'(data), 64'(32'hC0DE_0000 + 32'(g) * 32'h1111));
    chk({tag, ".locked"}, 64'(locked), 64'(lk));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_lock  = 4'b0000;
    full      = 1'b0;
    stat_clr  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      req_data[k*DATA_W +: DATA_W] = 32'hC0DE_0000 + 32'(k) * 32'h1111;

    // Reset state
    #1;
    chk("rst.push",   64'(push), 64'd0);
    chk("rst.ready",  64'(req_ready), 64'd0);
    chk("rst.locked", 64'(locked), 64'd0);
    chk("rst.stat",   64'(stat_cnt), 64'd0);
    tick();
    rst = 1'b0;

    // Plain round robin over all four
    for (int i = 0; i < 8; i++) begin
      #1;
      expect_beat("rr", i % 4, 1'b0);
      tick();
    end

    // FIFO full blocks everything, then 0 and 2 alternate
    req_valid = 4'b0101;
    full      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full.push",  64'(push), 64'd0);
      chk("full.ready", 64'(req_ready), 64'd0);
      tick();
    end
    full = 1'b0;
    #1; expect_beat("full_rel0", 0, 1'b0); tick();
    #1; expect_beat("full_rel1", 2, 1'b0); tick();

    // Move pointer to 1, then a 4-beat locked burst from requester 1
    req_valid = 4'b1111;
    #1; expect_beat("pre3", 3, 1'b0); tick();
    #1; expect_beat("pre0", 0, 1'b0); tick();
    req_lock = 4'b0010;
    for (int b = 1; b <= 3; b++) begin
      #1;
      expect_beat("burst", 1, (b > 1));
      tick();
    end
    req_lock = 4'b0000;
    #1; expect_beat("burst_last", 1, 1'b1); tick();
    #1; expect_beat("post_burst", 2, 1'b0); tick();

    // Requester 2 locks then goes silent: timeout after LOCK_TO cycles
    req_valid = 4'b0100;
    req_lock  = 4'b0100;
    #1; expect_beat("to_lock", 2, 1'b0); tick();
    req_valid = 4'b1011;
    req_lock  = 4'b0000;
    for (int i = 0; i < LOCK_TO; i++) begin
      #1;
      chk("to_wait.locked", 64'(locked), 64'd1);
      chk("to_wait.push",   64'(push), 64'd0);
      tick();
    end
    #1; expect_beat("to_after", 3, 1'b0); tick();

    // Reset in the middle of a lock
    req_valid = 4'b0100;
    req_lock  = 4'b0100;
    #1; expect_beat("rl_lock", 2, 1'b0); tick();
    req_valid = 4'b1111;
    req_lock  = 4'b1111;
    #1; expect_beat("rl_inlock", 2, 1'b1);
    rst = 1'b1;
    #1;
    chk("rl_rst.push",   64'(push), 64'd0);
    chk("rl_rst.ready",  64'(req_ready), 64'd0);
    chk("rl_rst.locked", 64'(locked), 64'd0);
    tick();
    rst      = 1'b0;
    req_lock = 4'b0000;
    #1; expect_beat("rl_after", 0, 1'b0); tick();

    // No valid requester, then statistics
    req_valid = 4'b0000;
    stat_clr  = 1'b1;
    #1;
    chk("none.push",  64'(push), 64'd0);
    chk("none.grant", 64'(grant), 64'd0);
    tick();
    stat_clr  = 1'b0;
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      expect_beat("stat_beat", 0, 1'b0);
      tick();
    end
    req_valid = 4'b0000;
    #1;
    chk("stat.req0", 64'(stat_cnt[15:0]), 64'(EXP_STAT5));
    chk("stat.req1", 64'(stat_cnt[31:16]), 64'd0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    chk("stat.clr", 64'(stat_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
